// File: rtl/registers_pkg.sv
// Shared sizing constants for the little-computer register file.
// Feeds the parameter defaults of the registers block.
package registers_pkg;

  localparam int RegWidth     = 16;
  localparam int NumRegs      = 8;
  localparam int NumRegsWidth = 3;

endpackage

// File: rtl/registers.sv
// General-purpose register file: two combinational read ports,
// one synchronous write port, and a parallel debug view.
module registers
  import registers_pkg::*;
#(
  parameter int REG_WIDTH      = RegWidth,
  parameter int NUM_REGS       = NumRegs,
  parameter int NUM_REGS_WIDTH = NumRegsWidth
) (
  input  logic [NUM_REGS_WIDTH-1:0] rs,
  input  logic [NUM_REGS_WIDTH-1:0] rt,
  input  logic [NUM_REGS_WIDTH-1:0] rd,
  input  logic [REG_WIDTH-1:0]      reg_in,
  input  logic                      reg_write_en,
  input  logic                      CLK,
  output logic [REG_WIDTH-1:0]      rs_val,
  output logic [REG_WIDTH-1:0]      rt_val,
  output logic [REG_WIDTH-1:0]      reg_state [NUM_REGS],
  input  logic                      RST
);

  logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  w_we;

  // Out-of-range rd matches no slot, so such writes fall away.
  always_comb begin
    w_we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_we[i] = reg_write_en &&
                (rd == NUM_REGS_WIDTH'(i));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= reg_in;
        end
      end
    end
  end

  // Out-of-range read indices select nothing and yield zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs == NUM_REGS_WIDTH'(i)) begin
        rs_val = r_regs[i];
      end
      if (rt == NUM_REGS_WIDTH'(i)) begin
        rt_val = r_regs[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_state[i] = r_regs[i];
    end
  end

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the register file: vector table,
// directed corner sequences and a random run against a model.
module tb_registers;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  rs, rt, rd;
  logic [15:0] din;
  logic        we;

  logic [15:0] rs_val, rt_val;
  logic [15:0] rstate [8];
  logic [15:0] rs_val5, rt_val5;
  logic [15:0] rstate5 [5];

  logic [15:0] model [8];
  logic [15:0] m5 [5];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  rd;
    logic [15:0] din;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] ers;
    logic [15:0] ert;
  } vec_t;

  vec_t vt [6];

  always #5 CLK = ~CLK;

  registers u_dut (
    .rs(rs), .rt(rt), .rd(rd),
    .reg_in(din), .reg_write_en(we),
    .CLK(CLK),
    .rs_val(rs_val), .rt_val(rt_val),
    .reg_state(rstate),
    .RST(RST)
  );

  registers #(
    .REG_WIDTH(16), .NUM_REGS(5),
    .NUM_REGS_WIDTH(3)
  ) u_dut5 (
    .rs(rs), .rt(rt), .rd(rd),
    .reg_in(din), .reg_write_en(we),
    .CLK(CLK),
    .rs_val(rs_val5), .rt_val(rt_val5),
    .reg_state(rstate5),
    .RST(RST)
  );

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp5(
    input logic [2:0] idx);
    return (idx < 5) ? m5[idx] : 16'h0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 0; i < 5; i++) m5[i] = '0;
  endtask

  // One rising edge; the model takes the write the DUT should see.
  task automatic step();
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
    w = we && !RST;
    a = rd;
    d = din;
    @(posedge CLK);
    #1;
    if (w) begin
      model[a] = d;
      if (a < 5) m5[a] = d;
    end
  endtask

  task automatic chk_state(input string nm);
    for (int i = 0; i < 8; i++)
      chk(nm, rstate[i], model[i]);
    for (int i = 0; i < 5; i++)
      chk({nm, "5"}, rstate5[i], m5[i]);
  endtask

  initial begin
    vt[0] = '{1'b0, 3'd0, 16'h0001, 3'd0, 3'd0,
              16'h0000, 16'h0000};
    vt[1] = '{1'b1, 3'd0, 16'h0001, 3'd0, 3'd1,
              16'h0001, 16'h0000};
    vt[2] = '{1'b1, 3'd3, 16'hAAAA, 3'd3, 3'd0,
              16'hAAAA, 16'h0001};
    vt[3] = '{1'b0, 3'd3, 16'h5555, 3'd3, 3'd3,
              16'hAAAA, 16'hAAAA};
    vt[4] = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd3,
              16'hFFFF, 16'hAAAA};
    vt[5] = '{1'b1, 3'd0, 16'h0000, 3'd0, 3'd7,
              16'h0000, 16'hFFFF};

    RST = 1'b1;
    we  = 1'b0;
    rd  = '0;
    rs  = '0;
    rt  = '0;
    din = '0;
    clear_model();
    #2;
    chk_state("reset_state");
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rs = 3'(i);
      rt = 3'(i);
      #1;
      chk("sweep_rs", rs_val, 16'h0);
      chk("sweep_rt", rt_val, 16'h0);
    end

    for (int k = 0; k < 6; k++) begin
      we  = vt[k].we;
      rd  = vt[k].rd;
      din = vt[k].din;
      rs  = vt[k].rs;
      rt  = vt[k].rt;
      step();
      chk("vec_rs", rs_val, vt[k].ers);
      chk("vec_rt", rt_val, vt[k].ert);
    end

    for (int i = 0; i < 8; i++) begin
      we  = 1'b1;
      rd  = 3'(i);
      din = 16'h10 + 16'(i);
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rs = 3'(i);
      rt = 3'(7 - i);
      #1;
      chk("all_rs", rs_val, 16'h10 + 16'(i));
      chk("all_rt", rt_val, 16'h17 - 16'(i));
    end
    chk_state("all_state");

    we  = 1'b1;
    rd  = 3'd3;
    din = 16'hAAAA;
    step();
    din = 16'h5555;
    rs  = 3'd3;
    rt  = 3'd3;
    #1;
    chk("rw_before", rs_val, 16'hAAAA);
    chk("rw_before_t", rt_val, 16'hAAAA);
    step();
    chk("rw_after", rs_val, 16'h5555);
    chk("rw_after_t", rt_val, 16'h5555);

    for (int k = 0; k < 300; k++) begin
      we  = 1'($urandom_range(0, 1));
      rd  = 3'($urandom);
      din = 16'($urandom);
      rs  = 3'($urandom);
      rt  = 3'($urandom);
      #1;
      chk("rnd_rs", rs_val, model[rs]);
      chk("rnd_rt", rt_val, model[rt]);
      chk("rnd_rs5", rs_val5, exp5(rs));
      chk("rnd_rt5", rt_val5, exp5(rt));
      step();
      chk_state("rnd_state");
    end

    we  = 1'b0;
    rs  = 3'd6;
    rt  = 3'd7;
    #1;
    chk("oor_rs5", rs_val5, 16'h0);
    chk("oor_rt5", rt_val5, 16'h0);

    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    clear_model();
    chk_state("async_rst");
    chk("async_rs", rs_val, 16'h0);
    chk("async_rt", rt_val, 16'h0);

    we  = 1'b1;
    rd  = 3'd2;
    din = 16'h1234;
    rs  = 3'd2;
    step();
    chk("rst_blocks_wr", rs_val, 16'h0);
    chk_state("rst_hold");

    @(negedge CLK);
    RST = 1'b0;
    step();
    chk("first_wr", rs_val, 16'h1234);
    chk("first_wr5", rs_val5, 16'h1234);
    chk_state("post_rst");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
